// File: rtl/frame_thr_pkg.sv
// Shared definitions for the multi-lane frame thresholder.
//   lane_state_e      : per-lane parser state (IDLE, TS, DATA)
//   START_WORD_DEF    : default frame start marker
//   END_WORD_DEF      : default frame end marker
//   POST_TRIGGER_DEF  : default decision hold length in cycles
package frame_thr_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_TS   = 2'd1,
    LANE_DATA = 2'd2
  } lane_state_e;

  localparam logic [15:0] START_WORD_DEF   = 16'hDEAD;
  localparam logic [15:0] END_WORD_DEF     = 16'hBEEF;
  localparam logic [15:0] POST_TRIGGER_DEF = 16'd10;

endpackage

// File: rtl/frame_lane_parser.sv
// One RX lane: input register, frame parser FSM, time-stamp latch and
// threshold compare.
//   clk_i, rst_i     : clock, async active-high reset
//   syncstatus_i     : lane sync flags, word valid only when 2'b11
//   datak_i          : lane control flags, word valid only when 2'b00
//   data_i           : lane word
//   threshold_i      : unsigned compare level
//   mode_i           : 0 hit when word > threshold, 1 hit when word < threshold
//   hit_o            : registered hit, one cycle after the input register
//   ts_o             : time stamp of the current/last frame
//   frame_error_o    : sticky framing error
module frame_lane_parser
  import frame_thr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FRAME_LEN  = 128,
  parameter logic [DATA_WIDTH-1:0] START_WORD = START_WORD_DEF,
  parameter logic [DATA_WIDTH-1:0] END_WORD   = END_WORD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            syncstatus_i,
  input  logic [1:0]            datak_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] threshold_i,
  input  logic                  mode_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] ts_o,
  output logic                  frame_error_o
);

  localparam int                IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // Input register stage
  logic                  in_valid_q;
  logic [DATA_WIDTH-1:0] in_word_q;

  // Parser state
  lane_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] ts_q, ts_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic                  err_event;

  logic is_start;
  logic is_end;
  logic cmp_hit;

  assign is_start = (in_word_q == START_WORD);
  assign is_end   = (in_word_q == END_WORD);
  assign cmp_hit  = mode_i ? (in_word_q < threshold_i) : (in_word_q > threshold_i);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_valid_q <= 1'b0;
      in_word_q  <= '0;
      state_q    <= LANE_IDLE;
      idx_q      <= '0;
      ts_q       <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_valid_q <= (syncstatus_i == 2'b11) && (datak_i == 2'b00);
      in_word_q  <= data_i;
      state_q    <= state_d;
      idx_q      <= idx_d;
      ts_q       <= ts_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. Any invalid word outside IDLE aborts the frame.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_event = 1'b0;
    unique case (state_q)
      LANE_IDLE: begin
        if (in_valid_q && is_start) begin
          state_d = LANE_TS;
          idx_d   = IDX_W'(1);
        end
      end
      LANE_TS: begin
        if (!in_valid_q) begin
          err_event = 1'b1;
          state_d   = LANE_IDLE;
        end else begin
          state_d = LANE_DATA;
          idx_d   = IDX_W'(2);
        end
      end
      LANE_DATA: begin
        if (!in_valid_q) begin
          err_event = 1'b1;
          state_d   = LANE_IDLE;
        end else if (idx_q == LAST_IDX) begin
          // Last slot of the frame must carry the end marker.
          err_event = !is_end;
          state_d   = LANE_IDLE;
        end else if (is_start || is_end) begin
          err_event = 1'b1;
          state_d   = LANE_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = LANE_IDLE;
    endcase
  end

  // Output logic: only genuine data words of a frame may hit.
  always_comb begin
    hit_d = (state_q == LANE_DATA) && in_valid_q && (idx_q != LAST_IDX) &&
            !is_start && !is_end && cmp_hit;
    ts_d  = ((state_q == LANE_TS) && in_valid_q) ? in_word_q : ts_q;
    err_d = err_q | err_event;
  end

  assign hit_o         = hit_q;
  assign ts_o          = ts_q;
  assign frame_error_o = err_q;

endmodule

// File: rtl/frame_thresholder_multi.sv
// Multi-lane frame thresholder. Each lane is parsed and compared in its own
// frame_lane_parser; this level forms the N-of-M coincidence and owns the
// trigger window.
//   rx_std_clkout                   : clock for all lanes
//   rst                             : async active-high reset
//   rx_syncstatus / rx_datak        : per-lane 2-bit flags, lane i = [2i+1:2i]
//   RX_data                         : per-lane words, lane i = [i*DW +: DW]
//   cfg_threshold / cfg_mode        : compare level and direction
//   cfg_min_hits                    : coincidence count (0 behaves as 1)
//   triggering_time_stamp           : TS of lowest-index hit lane at trigger
//   threshold_decision_to_DRAM_ctrl : high for POST_TRIGGER_ENDING cycles
//   ch_hit_mask                     : hit vector captured at trigger
//   frame_error                     : sticky per-lane framing error
//   trigger_count                   : accepted triggers, wrapping
module frame_thresholder_multi
  import frame_thr_pkg::*;
#(
  parameter int                    NUM_CH              = 8,
  parameter int                    DATA_WIDTH          = 16,
  parameter int                    FRAME_LEN           = 128,
  parameter logic [DATA_WIDTH-1:0] START_WORD          = START_WORD_DEF,
  parameter logic [DATA_WIDTH-1:0] END_WORD            = END_WORD_DEF,
  parameter logic [15:0]           POST_TRIGGER_ENDING = POST_TRIGGER_DEF
) (
  input  logic                           rx_std_clkout,
  input  logic                           rst,
  input  logic [2*NUM_CH-1:0]            rx_syncstatus,
  input  logic [2*NUM_CH-1:0]            rx_datak,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   RX_data,
  input  logic [DATA_WIDTH-1:0]          cfg_threshold,
  input  logic [$clog2(NUM_CH+1)-1:0]    cfg_min_hits,
  input  logic                           cfg_mode,
  output logic [DATA_WIDTH-1:0]          triggering_time_stamp,
  output logic                           threshold_decision_to_DRAM_ctrl,
  output logic [NUM_CH-1:0]              ch_hit_mask,
  output logic [NUM_CH-1:0]              frame_error,
  output logic [15:0]                    trigger_count
);

  localparam int CNT_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]     hit_vec;
  logic [DATA_WIDTH-1:0] lane_ts [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    frame_lane_parser #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAME_LEN  (FRAME_LEN),
      .START_WORD (START_WORD),
      .END_WORD   (END_WORD)
    ) u_lane (
      .clk_i         (rx_std_clkout),
      .rst_i         (rst),
      .syncstatus_i  (rx_syncstatus[2*g +: 2]),
      .datak_i       (rx_datak[2*g +: 2]),
      .data_i        (RX_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .threshold_i   (cfg_threshold),
      .mode_i        (cfg_mode),
      .hit_o         (hit_vec[g]),
      .ts_o          (lane_ts[g]),
      .frame_error_o (frame_error[g])
    );
  end

  logic [CNT_W-1:0]      hit_cnt;
  logic [CNT_W-1:0]      min_eff;
  logic [DATA_WIDTH-1:0] first_ts;
  logic                  fire;

  // Population count of the per-cycle hit vector.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_cnt = hit_cnt + CNT_W'(hit_vec[i]);
    end
  end

  // Priority encoder: scanning downward leaves the lowest hit lane's TS.
  always_comb begin
    first_ts = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit_vec[i]) first_ts = lane_ts[i];
    end
  end

  assign min_eff = (cfg_min_hits == '0) ? CNT_W'(1) : cfg_min_hits;

  // Decision stays high while holding, so it doubles as the hold flag.
  logic                  decision_q, decision_d;
  logic [15:0]           hold_q, hold_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [DATA_WIDTH-1:0] tstamp_q, tstamp_d;
  logic [15:0]           count_q, count_d;

  assign fire = (hit_cnt >= min_eff) && !decision_q;

  // State register
  always_ff @(posedge rx_std_clkout or posedge rst) begin
    if (rst) begin
      decision_q <= 1'b0;
      hold_q     <= '0;
      mask_q     <= '0;
      tstamp_q   <= '0;
      count_q    <= '0;
    end else begin
      decision_q <= decision_d;
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      tstamp_q   <= tstamp_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic. The counter is loaded with N-1 so that the drop on the
  // edge after it reaches zero yields exactly N high cycles.
  always_comb begin
    decision_d = decision_q;
    hold_d     = hold_q;
    mask_d     = mask_q;
    tstamp_d   = tstamp_q;
    count_d    = count_q;
    if (fire) begin
      decision_d = 1'b1;
      hold_d     = POST_TRIGGER_ENDING - 16'd1;
      mask_d     = hit_vec;
      tstamp_d   = first_ts;
      count_d    = count_q + 16'd1;
    end else if (decision_q) begin
      if (hold_q == 16'd0) begin
        decision_d = 1'b0;
      end else begin
        hold_d = hold_q - 16'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    threshold_decision_to_DRAM_ctrl = decision_q;
    ch_hit_mask                     = mask_q;
    triggering_time_stamp           = tstamp_q;
    trigger_count                   = count_q;
  end

endmodule

// File: tb/tb_frame_thresholder_multi.sv
// Bench for frame_thresholder_multi: a table of frame scenarios is replayed on
// all eight lanes; expected triggers go into a queue when the crossing word is
// driven and are popped when the decision rises.
module tb_frame_thresholder_multi;

  localparam int NCH     = 8;
  localparam int FLEN    = 128;
  localparam int RUN_LEN = 150;
  localparam int EXP_W   = 32 + 8 + 16 + 16;

  logic               clk;
  logic               rst;
  logic [2*NCH-1:0]   rx_syncstatus;
  logic [2*NCH-1:0]   rx_datak;
  logic [NCH*16-1:0]  RX_data;
  logic [15:0]        cfg_threshold;
  logic [3:0]         cfg_min_hits;
  logic               cfg_mode;
  logic [15:0]        triggering_time_stamp;
  logic               decision;
  logic [NCH-1:0]     ch_hit_mask;
  logic [NCH-1:0]     frame_error;
  logic [15:0]        trigger_count;

  frame_thresholder_multi dut (
    .rx_std_clkout                   (clk),
    .rst                             (rst),
    .rx_syncstatus                   (rx_syncstatus),
    .rx_datak                        (rx_datak),
    .RX_data                         (RX_data),
    .cfg_threshold                   (cfg_threshold),
    .cfg_min_hits                    (cfg_min_hits),
    .cfg_mode                        (cfg_mode),
    .triggering_time_stamp           (triggering_time_stamp),
    .threshold_decision_to_DRAM_ctrl (decision),
    .ch_hit_mask                     (ch_hit_mask),
    .frame_error                     (frame_error),
    .trigger_count                   (trigger_count)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenario table ----------------
  typedef struct packed {
    logic [15:0]        thr;
    logic               mode;
    logic [3:0]         min_hits;
    logic [15:0]        base;
    logic [15:0]        ts_base;   // lane l time stamp = ts_base + 16*l
    logic [3:0]         skew;      // lane l frame starts l*skew cycles late
    logic [3:0]         np;
    logic [7:0][2:0]    p_lane;
    logic [7:0][6:0]    p_idx;
    logic [7:0][15:0]   p_val;
    logic [1:0]         bad_kind;  // 0 none, 1 word override, 2 sync lost
    logic [2:0]         bad_lane;
    logic [6:0]         bad_idx;
    logic [15:0]        bad_word;
    logic [1:0]         nt;
    logic [1:0][7:0]    t_pos;     // run cycle of the triggering word
    logic [1:0][7:0]    t_mask;
    logic [1:0][15:0]   t_ts;
    logic [7:0]         exp_err;   // cumulative sticky errors after the run
  } vec_t;

  function automatic vec_t new_vec(input logic [15:0] thr, input logic mode,
                                   input logic [3:0] mh, input logic [15:0] base,
                                   input logic [15:0] tsb, input logic [3:0] skew,
                                   input logic [7:0] err);
    vec_t v;
    v          = '0;
    v.thr      = thr;
    v.mode     = mode;
    v.min_hits = mh;
    v.base     = base;
    v.ts_base  = tsb;
    v.skew     = skew;
    v.exp_err  = err;
    return v;
  endfunction

  function automatic vec_t add_probe(input vec_t v, input int lane, input int idx,
                                     input logic [15:0] val);
    v.p_lane[v.np] = 3'(lane);
    v.p_idx[v.np]  = 7'(idx);
    v.p_val[v.np]  = val;
    v.np           = v.np + 4'd1;
    return v;
  endfunction

  function automatic vec_t add_trig(input vec_t v, input int t, input logic [7:0] m,
                                    input logic [15:0] ts);
    v.t_pos[v.nt]  = 8'(t);
    v.t_mask[v.nt] = m;
    v.t_ts[v.nt]   = ts;
    v.nt           = v.nt + 2'd1;
    return v;
  endfunction

  function automatic vec_t set_bad(input vec_t v, input logic [1:0] kind, input int lane,
                                   input int idx, input logic [15:0] w);
    v.bad_kind = kind;
    v.bad_lane = 3'(lane);
    v.bad_idx  = 7'(idx);
    v.bad_word = w;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [15:0]      exp_count = '0;
  logic [7:0]       last_mask = '0;
  logic [15:0]      last_ts   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input vec_t v, input int t);
    for (int l = 0; l < NCH; l++) begin
      int          pos;
      logic [15:0] w;
      logic        sync_ok;
      pos     = t - l * int'(v.skew);
      w       = 16'h1234;  // valid filler outside frames, must be ignored
      sync_ok = 1'b1;
      if (pos == 0) w = 16'hDEAD;
      else if (pos == 1) w = v.ts_base + 16'(l * 16);
      else if (pos == FLEN - 1) w = 16'hBEEF;
      else if (pos > 1 && pos < FLEN - 1) begin
        w = v.base;
        for (int k = 0; k < int'(v.np); k++) begin
          if (int'(v.p_lane[k]) == l && int'(v.p_idx[k]) == pos) w = v.p_val[k];
        end
      end
      if (v.bad_kind != 2'd0 && int'(v.bad_lane) == l && int'(v.bad_idx) == pos) begin
        if (v.bad_kind == 2'd1) w = v.bad_word;
        else sync_ok = 1'b0;
      end
      RX_data[l*16 +: 16]     = w;
      rx_syncstatus[2*l +: 2] = sync_ok ? 2'b11 : 2'b01;
      rx_datak[2*l +: 2]      = 2'b00;
    end
    for (int k = 0; k < int'(v.nt); k++) begin
      if (int'(v.t_pos[k]) == t) begin
        exp_count = exp_count + 16'd1;
        last_mask = v.t_mask[k];
        last_ts   = v.t_ts[k];
        // Word sampled next edge, decision two edges later.
        exp_q.push_back({32'(cyc + 3), v.t_mask[k], v.t_ts[k], exp_count});
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int rst_t);
    cfg_threshold = v.thr;
    cfg_mode      = v.mode;
    cfg_min_hits  = v.min_hits;
    for (int t = 0; t < RUN_LEN; t++) begin
      if (t == rst_t) begin
        check("pre_rst_frame_error", 32'(frame_error), 32'h80);
        check("pre_rst_count", 32'(trigger_count), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_decision", 32'(decision), 32'd0);
        check("rst_mask", 32'(ch_hit_mask), 32'd0);
        check("rst_ts", 32'(triggering_time_stamp), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_count", 32'(trigger_count), 32'd0);
        exp_count = '0;
        last_mask = '0;
        last_ts   = '0;
        @(negedge clk);
        check("rst_hold_outputs",
              {7'd0, decision, ch_hit_mask, frame_error, trigger_count[7:0]}, 32'd0);
        rst = 1'b0;
      end
      drive_cycle(v, t);
      @(negedge clk);
    end
    check("pending_triggers", 32'(exp_q.size()), 32'd0);
    check("frame_error", 32'(frame_error), 32'(v.exp_err));
    check("mask_after_window", 32'(ch_hit_mask), 32'(last_mask));
    check("ts_after_window", 32'(triggering_time_stamp), 32'(last_ts));
    check("count_after_run", 32'(trigger_count), 32'(exp_count));
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic             dec_prev;
    int               run_len;
    logic [EXP_W-1:0] e;
    logic [7:0]       rise_mask;
    logic [15:0]      rise_ts;
    logic [15:0]      rise_cnt;
    dec_prev  = 1'b0;
    run_len   = 0;
    rise_mask = '0;
    rise_ts   = '0;
    rise_cnt  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dec_prev = 1'b0;
        run_len  = 0;
      end else begin
        if (decision && !dec_prev) begin
          run_len   = 1;
          rise_mask = ch_hit_mask;
          rise_ts   = triggering_time_stamp;
          rise_cnt  = trigger_count;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_trigger: decision rose at cycle %0d, expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("trigger_cycle", 32'(cyc), e[71:40]);
            check("trigger_mask", 32'(ch_hit_mask), 32'(e[39:32]));
            check("trigger_ts", 32'(triggering_time_stamp), 32'(e[31:16]));
            check("trigger_count", 32'(trigger_count), 32'(e[15:0]));
          end
        end else if (decision) begin
          run_len++;
        end else if (dec_prev) begin
          check("window_length", 32'(run_len), 32'd10);
          check("frozen_mask", 32'(ch_hit_mask), 32'(rise_mask));
          check("frozen_ts", 32'(triggering_time_stamp), 32'(rise_ts));
          check("frozen_count", 32'(trigger_count), 32'(rise_cnt));
        end
        dec_prev = decision;
      end
    end
  end

  // ---------------- main sequence ----------------
  vec_t vr;
  vec_t vecs [11];

  initial begin : main
    // Reset mid-frame: trigger and lane-7 error first, then reset at idx 60;
    // the post-reset crossing at idx 80 belongs to a discarded frame.
    vr = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0700, 4'd0, 8'h00);
    vr = add_probe(vr, 0, 30, 16'h0060);
    vr = add_probe(vr, 0, 80, 16'h0060);
    vr = set_bad(vr, 2'd1, 7, 40, 16'hDEAD);
    vr = add_trig(vr, 30, 8'h01, 16'h0700);

    // Single hit on lane 1; words equal to / below threshold do not hit.
    vecs[0] = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0000, 4'd0, 8'h00);
    vecs[0] = add_probe(vecs[0], 1, 17, 16'h004F);
    vecs[0] = add_probe(vecs[0], 1, 18, 16'h0050);
    vecs[0] = add_probe(vecs[0], 1, 19, 16'h0051);
    vecs[0] = add_trig(vecs[0], 19, 8'h02, 16'h0010);
    // Two lanes together plus one a cycle later: below 3-of-8.
    vecs[1] = new_vec(16'h0050, 1'b0, 4'd3, 16'h0040, 16'h0000, 4'd0, 8'h00);
    vecs[1] = add_probe(vecs[1], 2, 50, 16'h0080);
    vecs[1] = add_probe(vecs[1], 5, 50, 16'h0080);
    vecs[1] = add_probe(vecs[1], 4, 51, 16'h0080);
    // Three lanes together: trigger, TS from lane 2.
    vecs[2] = new_vec(16'h0050, 1'b0, 4'd3, 16'h0040, 16'h0000, 4'd0, 8'h00);
    vecs[2] = add_probe(vecs[2], 2, 50, 16'h0080);
    vecs[2] = add_probe(vecs[2], 4, 50, 16'h0080);
    vecs[2] = add_probe(vecs[2], 5, 50, 16'h0080);
    vecs[2] = add_trig(vecs[2], 50, 8'h34, 16'h0020);
    // Lane 3 END_WORD at idx 100; its later crossing is silent.
    vecs[3] = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0100, 4'd0, 8'h08);
    vecs[3] = set_bad(vecs[3], 2'd1, 3, 100, 16'hBEEF);
    vecs[3] = add_probe(vecs[3], 3, 110, 16'h0080);
    vecs[3] = add_probe(vecs[3], 0, 60, 16'h0090);
    vecs[3] = add_trig(vecs[3], 60, 8'h01, 16'h0100);
    // Misaligned frames coinciding in one cycle; lane 3 good again, error sticky.
    vecs[4] = new_vec(16'h0050, 1'b0, 4'd2, 16'h0040, 16'h0200, 4'd1, 8'h08);
    vecs[4] = add_probe(vecs[4], 3, 40, 16'h0099);
    vecs[4] = add_probe(vecs[4], 6, 37, 16'h0099);
    vecs[4] = add_trig(vecs[4], 43, 8'h48, 16'h0230);
    // Retrigger: +4 ignored, +12 (two after the fall) accepted.
    vecs[5] = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0300, 4'd0, 8'h08);
    vecs[5] = add_probe(vecs[5], 6, 20, 16'h0070);
    vecs[5] = add_probe(vecs[5], 6, 24, 16'h0070);
    vecs[5] = add_probe(vecs[5], 6, 32, 16'h0070);
    vecs[5] = add_trig(vecs[5], 20, 8'h40, 16'h0360);
    vecs[5] = add_trig(vecs[5], 32, 8'h40, 16'h0360);
    // Hold boundary: hit landing on the falling edge ignored, next one accepted.
    vecs[6] = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0400, 4'd0, 8'h08);
    vecs[6] = add_probe(vecs[6], 5, 20, 16'h0070);
    vecs[6] = add_probe(vecs[6], 5, 30, 16'h0070);
    vecs[6] = add_probe(vecs[6], 5, 31, 16'h0070);
    vecs[6] = add_trig(vecs[6], 20, 8'h20, 16'h0450);
    vecs[6] = add_trig(vecs[6], 31, 8'h20, 16'h0450);
    // Only markers, time stamps and idle filler exceed the threshold.
    vecs[7] = new_vec(16'h0100, 1'b0, 4'd1, 16'h0000, 16'hFF00, 4'd0, 8'h08);
    // Below-threshold mode, min_hits 0 acts as 1.
    vecs[8] = new_vec(16'h0001, 1'b1, 4'd0, 16'h0005, 16'h0500, 4'd0, 8'h08);
    vecs[8] = add_probe(vecs[8], 0, 70, 16'h0000);
    vecs[8] = add_trig(vecs[8], 70, 8'h01, 16'h0500);
    // All eight lanes at min_hits 8; lane 7 then loses sync inside DATA.
    vecs[9] = new_vec(16'h0050, 1'b0, 4'd8, 16'h0040, 16'h0600, 4'd0, 8'h88);
    for (int l = 0; l < NCH; l++) vecs[9] = add_probe(vecs[9], l, 90, 16'h0090);
    vecs[9] = add_trig(vecs[9], 90, 8'hFF, 16'h0600);
    vecs[9] = set_bad(vecs[9], 2'd2, 7, 100, 16'h0000);
    // Lane 1 last word is not END_WORD.
    vecs[10] = new_vec(16'h0050, 1'b0, 4'd1, 16'h0040, 16'h0000, 4'd0, 8'h8A);
    vecs[10] = set_bad(vecs[10], 2'd1, 1, 127, 16'h0000);

    rst           = 1'b1;
    rx_syncstatus = '0;
    rx_datak      = '0;
    RX_data       = '0;
    cfg_threshold = '0;
    cfg_min_hits  = '0;
    cfg_mode      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_decision", 32'(decision), 32'd0);
    check("reset_mask", 32'(ch_hit_mask), 32'd0);
    check("reset_ts", 32'(triggering_time_stamp), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_count", 32'(trigger_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_vec(vr, 60);
    for (int i = 0; i < 11; i++) run_vec(vecs[i], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
